// File: rtl/s_const_gen_pipe.sv
// Pipelined S-register constant generator: expands an A operand or selects a built-in float constant.
// Define S_CONST_GEN_NORM_EN to normalise the integer-to-float mode (j=2) in the output stage.
module s_const_gen_pipe #(
  parameter int AW  = 24,
  parameter int LAT = 2,
  parameter int TW  = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [2:0]    i_j,
  input  logic [AW-1:0] i_ak,
  input  logic [TW-1:0] i_dest,
  input  logic          i_flush,
  output logic          o_valid,
  output logic [63:0]   o_result,
  output logic [TW-1:0] o_dest,
  output logic          o_busy
);

  // Stages 1..NP hold raw operands; the output register is stage LAT.
  localparam int NP = LAT - 1;

  localparam logic [14:0] EXP_I2F = 15'o40060;

  logic [NP:1]   pv;
  logic [2:0]    pj    [1:NP];
  logic [AW-1:0] pak   [1:NP];
  logic [TW-1:0] pdest [1:NP];

  logic [AW-1:0] ak_l;
  logic [AW-1:0] mag;
  logic          sgn;
  logic [47:0]   coef;
  logic [63:0]   i2f;
  logic [63:0]   res_d;
  logic          load_out;

  assign ak_l = pak[NP];
  assign sgn  = ak_l[AW-1];
  assign mag  = sgn ? -ak_l : ak_l;
  assign coef = 48'(mag);

`ifdef S_CONST_GEN_NORM_EN
  logic [5:0]  lz;
  logic        found;
  logic [47:0] coef_n;
  logic [14:0] exp_n;

  always_comb begin
    lz    = 6'd0;
    found = 1'b0;
    for (int i = 47; i >= 0; i--) begin
      if (!found) begin
        if (coef[i]) found = 1'b1;
        else         lz    = lz + 6'd1;
      end
    end
    coef_n = coef << lz;
    exp_n  = EXP_I2F - {9'd0, lz};
    // A zero magnitude has no leading one; return true zero with the sign dropped.
    i2f = (coef == 48'd0) ? 64'd0 : {sgn, exp_n, coef_n};
  end
`else
  assign i2f = {sgn, EXP_I2F, coef};
`endif

  always_comb begin
    res_d = 64'd0;
    case (pj[NP])
      3'd0:    res_d = 64'(ak_l);
      3'd1:    res_d = 64'($signed(ak_l));
      3'd2:    res_d = i2f;
      3'd3:    res_d = 64'o0400606000000000000000;
      3'd4:    res_d = 64'o0400004000000000000000;
      3'd5:    res_d = 64'o0400014000000000000000;
      3'd6:    res_d = 64'o0400024000000000000000;
      default: res_d = 64'o0400034000000000000000;
    endcase
  end

  assign load_out = pv[NP] & ~i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int k = 1; k <= NP; k++) begin
        pj[k]    <= '0;
        pak[k]   <= '0;
        pdest[k] <= '0;
      end
      o_valid  <= 1'b0;
      o_result <= 64'd0;
      o_dest   <= '0;
    end else begin
      // A flush never kills the op issued on the same edge.
      pv[1] <= i_valid;
      if (i_valid) begin
        pj[1]    <= i_j;
        pak[1]   <= i_ak;
        pdest[1] <= i_dest;
      end
      for (int k = 2; k <= NP; k++) begin
        pv[k] <= pv[k-1] & ~i_flush;
        if (pv[k-1]) begin
          pj[k]    <= pj[k-1];
          pak[k]   <= pak[k-1];
          pdest[k] <= pdest[k-1];
        end
      end
      o_valid <= load_out;
      if (load_out) begin
        o_result <= res_d;
        o_dest   <= pdest[NP];
      end
    end
  end

  assign o_busy = (|pv) | o_valid;

endmodule

// File: tb/tb_s_const_gen_pipe.sv
// Scoreboard bench for s_const_gen_pipe (AW=24, LAT=4) with a value-level reference model.
module tb_s_const_gen_pipe;
  localparam int AW  = 24;
  localparam int LAT = 4;
  localparam int TW  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic [2:0]    i_j = '0;
  logic [AW-1:0] i_ak = '0;
  logic [TW-1:0] i_dest = '0;
  logic          i_flush = 1'b0;
  logic          o_valid;
  logic [63:0]   o_result;
  logic [TW-1:0] o_dest;
  logic          o_busy;

  s_const_gen_pipe #(.AW(AW), .LAT(LAT), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_j(i_j), .i_ak(i_ak),
    .i_dest(i_dest), .i_flush(i_flush), .o_valid(o_valid), .o_result(o_result),
    .o_dest(o_dest), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit [63:0]   res;
    bit [TW-1:0] dest;
    int          issue;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          flush_q[$];
  int          errors = 0;
  int          checks = 0;
  bit [63:0]   last_res = '0;
  bit [TW-1:0] last_dest = '0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Value semantics: signed interpretation, magnitude, float fields built from numbers.
  function automatic bit [63:0] model(bit [2:0] j, bit [AW-1:0] ak);
    longint sv, mag;
    bit neg;
    bit [63:0] r;
    int e2;
    sv = longint'(ak);
    if (ak[AW-1]) sv = sv - (longint'(1) << AW);
    neg = (sv < 0);
    mag = neg ? -sv : sv;
    case (j)
      3'd0: r = 64'(ak);
      3'd1: r = sv;
      3'd2: begin
`ifdef S_CONST_GEN_NORM_EN
        if (mag == 0) r = '0;
        else begin
          int e;
          longint c;
          c = mag;
          e = 'h4030;
          while (c < (longint'(1) << 47)) begin
            c = c * 2;
            e--;
          end
          r = {neg, e[14:0], c[47:0]};
        end
`else
        r = {neg, 15'h4030, mag[47:0]};
`endif
      end
      3'd3: r = {1'b0, 15'h4030, 48'hC000_0000_0000};
      default: begin
        e2 = 'h4000 + int'(j) - 4;
        r = {1'b0, e2[14:0], 48'h8000_0000_0000};
      end
    endcase
    return r;
  endfunction

  task automatic drive(bit v, bit [2:0] j, bit [AW-1:0] ak, bit [TW-1:0] d, bit fl);
    exp_t e;
    @(posedge clk);
    #1;
    i_valid = v; i_j = j; i_ak = ak; i_dest = d; i_flush = fl;
    if (fl) flush_q.push_back(cyc + 1);
    if (v) begin
      e.res = model(j, ak);
      e.dest = d;
      e.issue = cyc + 1;
      e.due = cyc + LAT;
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      int f;
      bit busy_exp;
      exp_t keep[$];
      exp_t e;
      while (flush_q.size() > 0 && flush_q[0] <= cyc) begin
        f = flush_q.pop_front();
        keep = {};
        foreach (sb[i]) if (!(sb[i].issue < f && sb[i].due >= f)) keep.push_back(sb[i]);
        sb = keep;
      end
      busy_exp = 1'b0;
      foreach (sb[i]) if (sb[i].issue <= cyc) busy_exp = 1'b1;
      check("busy", 64'(o_busy), 64'(busy_exp));
      if (o_valid) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
          e = sb.pop_front();
          check("result", o_result, e.res);
          check("dest", 64'(o_dest), 64'(e.dest));
          last_res = e.res;
          last_dest = e.dest;
        end else begin
          checks++;
          errors++;
          $display("FAIL retire: unexpected o_valid at cycle %0d, actual=%h, required=no retire", cyc, o_result);
        end
      end else begin
        check("hold_result", o_result, last_res);
        check("hold_dest", 64'(o_dest), 64'(last_dest));
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          checks++;
          errors++;
          $display("FAIL retire: missing op tag %0d at cycle %0d, actual=idle required=%h", e.dest, cyc, e.res);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_result", o_result, 64'd0);
    check("rst_dest", 64'(o_dest), 64'd0);
    #11 rst_n = 1'b1;

    drive(1, 3'd0, 24'h800001, 3'd2, 0);
    drive(1, 3'd1, 24'h800001, 3'd5, 0);
    drive(0, 3'd0, 24'h0, 3'd0, 0);
    drive(1, 3'd2, 24'h000005, 3'd1, 0);
    drive(1, 3'd2, 24'hFFFFFF, 3'd6, 0);
    drive(1, 3'd2, 24'h000000, 3'd0, 0);
    drive(1, 3'd2, 24'h800000, 3'd7, 0);
    for (int m = 3; m <= 7; m++) drive(1, 3'(m), 24'h123456, 3'(m), 0);
    for (int i = 0; i < LAT + 2; i++) drive(0, 3'd0, 24'h0, 3'd0, 0);

    drive(1, 3'd5, 24'h0, 3'd1, 0);
    drive(1, 3'd6, 24'h0, 3'd2, 0);
    drive(1, 3'd7, 24'h0, 3'd3, 0);
    drive(1, 3'd0, 24'hABCDEF, 3'd4, 1);
    for (int i = 0; i < LAT + 2; i++) drive(0, 3'd0, 24'h0, 3'd0, 0);

    for (int i = 0; i < 400; i++) begin
      bit [AW-1:0] ak;
      case ($urandom_range(0, 9))
        0: ak = 24'h000000;
        1: ak = 24'h800000;
        2: ak = 24'hFFFFFF;
        3: ak = 24'h7FFFFF;
        default: ak = AW'($urandom);
      endcase
      drive($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), ak,
            TW'($urandom_range(0, 7)), $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < LAT + 2; i++) drive(0, 3'd0, 24'h0, 3'd0, 0);

    drive(1, 3'd1, 24'hF00001, 3'd1, 0);
    drive(1, 3'd2, 24'h000123, 3'd2, 0);
    drive(1, 3'd0, 24'h00FF00, 3'd3, 0);
    @(posedge clk);
    #1 i_valid = 1'b0;
    #2 rst_n = 1'b0;
    sb.delete();
    flush_q.delete();
    last_res = '0;
    last_dest = '0;
    #1;
    check("midrst_valid", 64'(o_valid), 64'd0);
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_result", o_result, 64'd0);
    check("midrst_dest", 64'(o_dest), 64'd0);
    #16 rst_n = 1'b1;
    for (int i = 0; i < LAT + 3; i++) drive(0, 3'd0, 24'h0, 3'd0, 0);

    for (int i = 0; i < 60; i++)
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), AW'($urandom),
            TW'($urandom_range(0, 7)), $urandom_range(0, 15) == 0);
    for (int i = 0; i < LAT + 3; i++) drive(0, 3'd0, 24'h0, 3'd0, 0);

    check("drain", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/s_const_gen_pipe.md
# s_const_gen_pipe

Parametrised, fully pipelined scalar constant generator for the S-register write path. Expands an A-register operand or selects a built-in floating-point constant according to the 3-bit j field. Carries a destination tag and a valid bit through a configurable-depth pipeline so results retire on a fixed cycle. Supports a flush of in-flight work and optional normalisation of the integer-to-float mode.

## Interface
- AW, 24: A-operand width; legal 16..48.
- LAT, 2: issue-to-result latency in clocks; legal 2..6.
- TW, 3: destination tag width (S register index).

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  issue strobe; one operation per cycle when high.
- i_j  in  3  mode select.
- i_ak  in  AW  A-register operand.
- i_dest  in  TW  destination tag.
- i_flush  in  1  kill all in-flight operations.
- o_valid  out  1  result strobe, one cycle per retired op.
- o_result  out  64  result word.
- o_dest  out  TW  tag of the retiring op.
- o_busy  out  1  high while any pipeline stage holds a valid op.

## Operation
- Word format: bit 63 sign, 62:48 biased exponent (bias 040000 octal), 47:0 coefficient.
- Stage 1 registers i_valid/i_j/i_ak/i_dest. Data registers load only when i_valid=1; valid always loads.
- Modes (mag = |ak| as AW-bit unsigned; ak=min negative gives mag = 2^(AW-1)):
  - 0: zero-extend ak to 64.
  - 1: sign-extend ak to 64.
  - 2: integer to float: {ak[AW-1], 15'o40060, mag zero-extended to 48}.
  - 3: 64'o0400606000000000000000 (0.75 × 2^48).
  - 4: 64'o0400004000000000000000 (0.5).
  - 5: 64'o0400014000000000000000 (1.0).
  - 6: 64'o0400024000000000000000 (2.0).
  - 7: 64'o0400034000000000000000 (4.0).
- Final stage registers o_result/o_dest only when its valid is set; otherwise they hold the last value.
- Tag passes unmodified; no reordering.
- i_flush at edge E clears valid in every stage holding an op issued before E. An op issued on the same edge (i_valid=1 at E) is accepted and retires normally.
- o_busy = OR of all stage valids, including output stage.

## Timing
- Issue at edge N → o_valid=1 during the cycle after edge N+LAT-1 (LAT edges including issue edge); o_valid high exactly one cycle per op.
- Throughput one op per clock; no backpressure, no stalls.
- Reset (any time, including mid-operation): all valids 0, o_valid 0, o_busy 0, o_result 0, o_dest 0. In-flight ops are lost. First issue accepted on first rising edge after rst_n deasserts.
- Extra stages beyond 2 are pure delay registers for valid/data/tag; the normaliser (if enabled) lives in the last stage.

## Configuration
- S_CONST_GEN_NORM_EN defined: mode 2 result normalised. lz = leading zeros of 48-bit coefficient; coefficient shifted left by lz; exponent = 040060 − lz; sign kept. mag = 0 yields 64'b0 (sign cleared).
- Not defined: mode 2 unnormalised as listed; mag = 0 yields {sign=0, 040060, 48'b0}. Other modes are identical in both builds. Latency is unchanged.

## Test plan
- AW=24, LAT=2: mode 0 ak=24'h800001 → 64'h0000000000800001; mode 1 same ak → 64'hFFFFFFFFFF800001; o_valid 2 clocks after issue, o_dest echoes i_dest.
- Mode 2, macro off: ak=5 → 64'h4030000000000005; ak=24'hFFFFFF → 64'hC030000000000001.
- Mode 2, macro on: ak=5 → 64'h4003A00000000000; ak=24'hFFFFFF → 64'hC001800000000000; ak=0 → 0.
- Modes 3..7 back-to-back, LAT=4, tags 3..7: five consecutive o_valid pulses, listed constants in order, o_busy high throughout then low one cycle after last.
- LAT=4: issue tags 1,2,3 on consecutive cycles, assert i_flush with issue of tag 4 → only tag 4 retires; o_result/o_dest hold the previous value until then.
- Assert rst_n low mid-stream with 3 ops in flight → o_valid/o_busy/o_result/o_dest go 0 immediately, no stale op retires after release.
